// File: rtl/letter_stepper.sv
// Letter-code sequencer: synchronized, debounced run/dir buttons drive a 0..6 stepper at DIV-cycle steps.
// All outputs are registered; a press acts 3+DEBOUNCE_CYCLES cycles after the raw edge. There is no backpressure.

module letter_stepper_debounce #(
   parameter int DEBOUNCE_CYCLES = 120_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic press
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          level_q, level_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          press_q, press_d;

   always_comb begin
      sync1_d = btn;
      sync2_d = sync1_q;
      level_d = level_q;
      cnt_d   = '0;
      // The counter runs only while the sample disagrees with the accepted level.
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      press_d = level_d & ~level_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign press = press_q;
endmodule

module letter_stepper #(
   parameter int CLK_HZ          = 12_000_000,
   parameter int STEP_HZ         = 2,
   parameter int DEBOUNCE_CYCLES = 120_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_run,
   input  logic       btn_dir,
   output logic [2:0] bin,
   output logic       running,
   output logic       dir,
   output logic       step_pulse
);
   localparam int DIV = CLK_HZ / STEP_HZ;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_PAUSE = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [2:0]    bin_q, bin_d;
   logic          dir_q, dir_d;
   logic          step_q, step_d;
   logic          tick;
   logic          run_press;
   logic          dir_press;

   letter_stepper_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_run),
      .press (run_press)
   );

   letter_stepper_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dir (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_dir),
      .press (dir_press)
   );

   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      bin_d   = bin_q;
      dir_d   = dir_q;
      step_d  = 1'b0;
      tick    = 1'b0;
      // Prescaler holds its phase while paused so a resume finishes the interrupted step.
      if (state_q == ST_RUN) begin
         tick  = (pre_q == PRE_LAST);
         pre_d = tick ? '0 : pre_q + 1'b1;
      end
      // Step uses the pre-toggle direction; an illegal 7 recovers to 0 either way.
      if (tick) begin
         step_d = 1'b1;
         if (!dir_q) begin
            bin_d = (bin_q >= 3'd6) ? 3'd0 : bin_q + 3'd1;
         end else if (bin_q == 3'd0) begin
            bin_d = 3'd6;
         end else if (bin_q == 3'd7) begin
            bin_d = 3'd0;
         end else begin
            bin_d = bin_q - 3'd1;
         end
      end
      if (run_press) begin
         state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
      end
      if (dir_press) begin
         dir_d = ~dir_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         pre_q   <= '0;
         bin_q   <= 3'd0;
         dir_q   <= 1'b0;
         step_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         bin_q   <= bin_d;
         dir_q   <= dir_d;
         step_q  <= step_d;
      end
   end

   assign bin        = bin_q;
   assign running    = (state_q == ST_RUN);
   assign dir        = dir_q;
   assign step_pulse = step_q;
endmodule

// File: tb/tb_letter_stepper.sv
// Bench for letter_stepper: directed scenarios plus random button traffic against a behavioural model,
// with expected steps queued by the model and popped by a monitor whenever step_pulse is seen.
module tb_letter_stepper;
   localparam int CLK_HZ = 10;
   localparam int STEP_HZ = 2;
   localparam int DB = 4;
   localparam int DIV = CLK_HZ / STEP_HZ;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_run;
   logic       btn_dir;
   logic [2:0] bin;
   logic       running;
   logic       dir;
   logic       step_pulse;

   letter_stepper #(.CLK_HZ(CLK_HZ), .STEP_HZ(STEP_HZ), .DEBOUNCE_CYCLES(DB)) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_run    (btn_run),
      .btn_dir    (btn_dir),
      .bin        (bin),
      .running    (running),
      .dir        (dir),
      .step_pulse (step_pulse)
   );

   always #5 clk = ~clk;

   typedef struct {
      int code;
      int cyc;
   } step_t;

   step_t exp_q[$];
   step_t e;
   int checks = 0;
   int errors = 0;
   int n_steps = 0;
   bit mon_en = 1'b0;

   // Reference model state
   int cyc = 0;
   int m_bin = 0;
   int m_elapsed = 0;
   bit m_run = 1'b1;
   bit m_dir = 1'b0;
   logic [63:0] h_run = '0;
   logic [63:0] h_dir = '0;
   bit lvl_run = 1'b0;
   bit lvl_dir = 1'b0;
   bit pend_run = 1'b0;
   bit pend_dir = 1'b0;
   bit np_run;
   bit np_dir;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // True when the last DB synchronized samples (raw delayed by two edges) all equal v.
   function automatic bit window_all(logic [63:0] h, bit v);
      for (int i = 2; i < DB + 2; i++) begin
         if (h[i] != v) return 1'b0;
      end
      return 1'b1;
   endfunction

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         m_bin = 0; m_run = 1'b1; m_dir = 1'b0; m_elapsed = 0;
         h_run = '0; h_dir = '0; lvl_run = 1'b0; lvl_dir = 1'b0;
         pend_run = 1'b0; pend_dir = 1'b0;
      end else begin
         if (m_run) begin
            if (m_elapsed % DIV == DIV - 1) begin
               m_bin = m_dir ? (m_bin + 6) % 7 : (m_bin + 1) % 7;
               exp_q.push_back('{m_bin, cyc});
            end
            m_elapsed++;
         end
         m_run = m_run ^ pend_run;
         m_dir = m_dir ^ pend_dir;
         h_run = {h_run[62:0], btn_run};
         h_dir = {h_dir[62:0], btn_dir};
         np_run = !lvl_run && window_all(h_run, 1'b1);
         np_dir = !lvl_dir && window_all(h_dir, 1'b1);
         if (window_all(h_run, !lvl_run)) lvl_run = !lvl_run;
         if (window_all(h_dir, !lvl_dir)) lvl_dir = !lvl_dir;
         pend_run = np_run;
         pend_dir = np_dir;
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            check("step_missing", 32'd0, 32'd1);
            void'(exp_q.pop_front());
         end
         if (step_pulse === 1'b1) begin
            n_steps++;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
               e = exp_q.pop_front();
               check("step_bin", {29'd0, bin}, e.code);
            end else begin
               check("step_unexpected", 32'd1, 32'd0);
            end
         end
         check("running", {31'd0, running}, {31'd0, m_run});
         check("dir", {31'd0, dir}, {31'd0, m_dir});
         check("bin", {29'd0, bin}, m_bin);
         check("bin_not_7", {31'd0, bin == 3'd7}, 32'd0);
      end
   end

   task automatic idle(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(bit r, bit d, int len);
      btn_run = r;
      btn_dir = d;
      idle(len);
      btn_run = 1'b0;
      btn_dir = 1'b0;
   endtask

   int s0;
   int k;

   initial begin
      rst = 1'b1; btn_run = 1'b0; btn_dir = 1'b0;
      idle(2);
      check("rst_bin", {29'd0, bin}, 32'd0);
      check("rst_running", {31'd0, running}, 32'd1);
      check("rst_dir", {31'd0, dir}, 32'd0);
      check("rst_step", {31'd0, step_pulse}, 32'd0);
      rst = 1'b0;
      mon_en = 1'b1;

      // Free run: 8 steps in 40 cycles
      s0 = n_steps;
      idle(40);
      #1;
      check("free_run_steps", n_steps - s0, 32'd8);
      check("free_run_bin", {29'd0, bin}, 32'd1);

      // Direction press latency and release
      btn_dir = 1'b1;
      idle(6);
      check("dir_early", {31'd0, dir}, 32'd0);
      idle(1);
      check("dir_toggled", {31'd0, dir}, 32'd1);
      idle(3);
      btn_dir = 1'b0;
      idle(20);
      check("dir_release", {31'd0, dir}, 32'd1);

      // Run glitch, pause, resume
      press(1'b1, 1'b0, 3);
      idle(10);
      check("glitch_running", {31'd0, running}, 32'd1);
      press(1'b1, 1'b0, 6);
      idle(15);
      check("paused", {31'd0, running}, 32'd0);
      press(1'b1, 1'b0, 6);
      idle(20);
      check("resumed", {31'd0, running}, 32'd1);

      // Dir press coinciding with a tick at bin 6
      if (m_dir) begin press(1'b0, 1'b1, 6); idle(10); end
      if (!m_run) begin press(1'b1, 1'b0, 6); idle(10); end
      k = 0;
      while (k < 200 && !(m_run && !m_dir && m_bin == 5 && m_elapsed % DIV == 3)) begin
         idle(1);
         k++;
      end
      check("align_found", {31'd0, k < 200}, 32'd1);
      press(1'b0, 1'b1, 6);
      idle(1);
      check("tick_dir_bin", {29'd0, bin}, 32'd0);
      check("tick_dir_dir", {31'd0, dir}, 32'd1);
      idle(5);
      check("tick_dir_next", {29'd0, bin}, 32'd6);

      // Reset mid-debounce while paused
      press(1'b1, 1'b0, 6);
      idle(8);
      btn_dir = 1'b1;
      idle(3);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      btn_dir = 1'b0;
      check("rst2_bin", {29'd0, bin}, 32'd0);
      check("rst2_running", {31'd0, running}, 32'd1);
      check("rst2_dir", {31'd0, dir}, 32'd0);
      idle(4);
      check("rst2_no_step", {31'd0, step_pulse}, 32'd0);
      idle(1);
      check("rst2_first_step", {31'd0, step_pulse}, 32'd1);
      check("rst2_first_bin", {29'd0, bin}, 32'd1);
      idle(10);

      // Random button traffic
      for (int it = 0; it < 150; it++) begin
         case ($urandom_range(0, 9))
            0, 1, 2: idle($urandom_range(1, 12));
            3, 4: begin press(1'b1, 1'b0, $urandom_range(1, 8)); idle($urandom_range(0, 6)); end
            5, 6: begin press(1'b0, 1'b1, $urandom_range(1, 8)); idle($urandom_range(0, 6)); end
            7: begin press(1'b1, 1'b1, $urandom_range(1, 8)); idle($urandom_range(0, 6)); end
            8: begin
               for (int j = 0; j < 8; j++) begin
                  btn_run = 1'($urandom_range(0, 1));
                  btn_dir = 1'($urandom_range(0, 1));
                  idle(1);
               end
               btn_run = 1'b0;
               btn_dir = 1'b0;
            end
            default: begin
               rst = 1'b1;
               idle($urandom_range(1, 2));
               rst = 1'b0;
            end
         endcase
      end

      idle(12);
      #1;
      check("queue_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
